// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered N-request arbiter with fixed-priority or
// round-robin selection and a valid/ack grant handshake. In fixed mode the
// highest-numbered request wins, matching the old 8-to-3 priority encoder.
module priority_arbiter_rr #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic            gnt_ack,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot,
  output logic [IDXW-1:0] last_idx
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N-1:0]      gnt_onehot_q, gnt_onehot_d;
  logic [IDXW-1:0]   last_idx_q, last_idx_d;

  logic              accept;
  logic              evaluate;
  logic [IDXW-1:0]   base_idx;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   pos;
  logic              sel_found;
  logic [IDXW-1:0]   sel_idx;

  // Selection: fixed mode is round-robin with the pointer pinned at 0, so a
  // single descending search from ptr-1 (wrapping, ptr itself last) covers both.
  // On an acceptance cycle the just-accepted index is the pointer, which lets
  // back-to-back grants rotate without waiting for last_idx to update.
  always_comb begin
    accept    = (state_q == GRANT) && gnt_ack;
    evaluate  = (state_q == IDLE) || accept;
    base_idx  = accept ? gnt_idx_q : last_idx_q;
    ptr       = mode ? base_idx : '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    pos       = '0;
    for (int k = N; k >= 1; k--) begin
      pos = IDXW'((int'(ptr) + N - k) % N);
      if (req[pos]) begin
        sel_found = 1'b1;
        sel_idx   = pos;
      end
    end
  end

  // Next-state: grants hold until accepted; an evaluation with no requests
  // returns to IDLE keeping the old index but clearing the one-hot.
  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    last_idx_d   = last_idx_q;
    if (accept) begin
      last_idx_d = gnt_idx_q;
    end
    if (evaluate) begin
      if (sel_found) begin
        state_d      = GRANT;
        gnt_idx_d    = sel_idx;
        gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
      end else begin
        state_d      = IDLE;
        gnt_onehot_d = '0;
      end
    end
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      last_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      last_idx_q   <= last_idx_d;
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign last_idx   = last_idx_q;

endmodule
